// File: rtl/avalon_st_pkt_pkg.sv
// Shared types and helpers for the Avalon-ST packet generator.
// Imported by the top and by the beat-pattern builder.
package avalon_st_pkt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_t;

    typedef enum logic {
        PatIncr  = 1'b0,
        PatConst = 1'b1
    } pattern_t;

    // Beats needed to carry a packet; a zero length is treated as one byte.
    function automatic int unsigned beats_for_len(input int unsigned len,
                                                  input int unsigned bytes);
        int unsigned eff_len;
        eff_len = (len == 0) ? 1 : len;
        return (eff_len + bytes - 1) / bytes;
    endfunction

endpackage

// File: rtl/avalon_st_beat_pattern.sv
// Combinational beat builder: fills one data word with the payload pattern,
// first symbol in the top byte, symbols past the valid count driven to zero.
module avalon_st_beat_pattern
    import avalon_st_pkt_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BYTES = WIDTH / 8,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned VB_W  = 4
) (
    input  logic [15:0]      pkt_idx_i,
    input  logic [LEN_W-1:0] byte_off_i,
    input  pattern_t         mode_i,
    input  logic [7:0]       seed_i,
    input  logic [VB_W-1:0]  valid_bytes_i,
    output logic [WIDTH-1:0] data_o
);

    logic [7:0] base;

    // Only the low byte of the sum matters: all pattern arithmetic is mod 256.
    assign base = 8'(32'(seed_i) + 32'(pkt_idx_i) + 32'(byte_off_i));

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (i < 32'(valid_bytes_i)) begin
                data_o[WIDTH-1-8*i -: 8] = (mode_i == PatConst) ? seed_i : base + 8'(i);
            end
        end
    end

endmodule

// File: rtl/avalon_st_pkt_gen.sv
// Avalon-ST packet generator: runs of fixed-length packets with a selectable
// payload pattern, programmable inter-packet gap and ready backpressure.
module avalon_st_pkt_gen
    import avalon_st_pkt_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned BYTES       = WIDTH / 8,
    parameter int unsigned EMPTY_WIDTH = $clog2(WIDTH / 8),
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned GAP_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic [15:0]            pkt_count,
    input  logic [GAP_W-1:0]       gap,
    input  logic                   mode,
    input  logic [7:0]             seed,
    output logic [WIDTH-1:0]       data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   sop,
    output logic                   eop,
    output logic [EMPTY_WIDTH-1:0] empty,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkts_sent
);

    localparam int unsigned VB_W = EMPTY_WIDTH + 1;

    if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_width_check
        $error("WIDTH must be a multiple of 8 and at least 16");
    end

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       nb_q, nb_d;
    logic [EMPTY_WIDTH-1:0] last_empty_q, last_empty_d;
    logic [15:0]            count_q, count_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    pattern_t               mode_q, mode_d;
    logic [7:0]             seed_q, seed_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]       beat_idx_q, beat_idx_d;
    logic [15:0]            pkts_sent_q, pkts_sent_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EMPTY_WIDTH-1:0] empty_q, empty_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [LEN_W-1:0]       start_len_eff;
    logic [LEN_W-1:0]       start_nb;
    logic [EMPTY_WIDTH-1:0] start_last_empty;

    // Parameters of the beat to be presented next, valid when load_beat is set.
    logic                   load_beat;
    logic                   clear_beat;
    logic [LEN_W-1:0]       nxt_idx;
    logic [LEN_W-1:0]       nxt_off;
    logic [15:0]            nxt_pkt;
    pattern_t               nxt_mode;
    logic [7:0]             nxt_seed;
    logic [LEN_W-1:0]       nxt_nb;
    logic [EMPTY_WIDTH-1:0] nxt_last_empty;
    logic                   nxt_eop;
    logic [VB_W-1:0]        vbytes;
    logic [WIDTH-1:0]       pat_data;

    assign start_len_eff    = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    assign start_nb         = LEN_W'(beats_for_len(32'(pkt_len), BYTES));
    assign start_last_empty = EMPTY_WIDTH'(32'(start_nb) * BYTES - 32'(start_len_eff));
    assign nxt_off          = LEN_W'(32'(nxt_idx) * BYTES);

    always_comb begin
        state_d        = state_q;
        nb_d           = nb_q;
        last_empty_d   = last_empty_q;
        count_d        = count_q;
        gap_d          = gap_q;
        mode_d         = mode_q;
        seed_d         = seed_q;
        gap_cnt_d      = gap_cnt_q;
        beat_idx_d     = beat_idx_q;
        pkts_sent_d    = pkts_sent_q;
        valid_d        = valid_q;
        sop_d          = sop_q;
        eop_d          = eop_q;
        empty_d        = empty_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        load_beat      = 1'b0;
        clear_beat     = 1'b0;
        nxt_idx        = beat_idx_q;
        nxt_pkt        = pkts_sent_q;
        nxt_mode       = mode_q;
        nxt_seed       = seed_q;
        nxt_nb         = nb_q;
        nxt_last_empty = last_empty_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d      = pkt_count;
                    gap_d        = gap;
                    mode_d       = pattern_t'(mode);
                    seed_d       = seed;
                    nb_d         = start_nb;
                    last_empty_d = start_last_empty;
                    pkts_sent_d  = '0;
                    busy_d       = 1'b1;
                    if (pkt_count == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        // Latched copies are not visible yet, so build from the inputs.
                        state_d        = StSend;
                        load_beat      = 1'b1;
                        nxt_idx        = '0;
                        nxt_pkt        = '0;
                        nxt_mode       = pattern_t'(mode);
                        nxt_seed       = seed;
                        nxt_nb         = start_nb;
                        nxt_last_empty = start_last_empty;
                    end
                end
            end
            StSend: begin
                if (valid_q && ready) begin
                    if (eop_q) begin
                        pkts_sent_d = pkts_sent_q + 16'd1;
                        if (pkts_sent_q + 16'd1 == count_q) begin
                            state_d    = StDone;
                            done_d     = 1'b1;
                            clear_beat = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d    = StGap;
                            gap_cnt_d  = gap_q;
                            clear_beat = 1'b1;
                        end else begin
                            load_beat = 1'b1;
                            nxt_idx   = '0;
                            nxt_pkt   = pkts_sent_q + 16'd1;
                        end
                    end else begin
                        load_beat = 1'b1;
                        nxt_idx   = beat_idx_q + LEN_W'(1);
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = StSend;
                    load_beat = 1'b1;
                    nxt_idx   = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        nxt_eop = (nxt_idx == nxt_nb - LEN_W'(1));
        vbytes  = nxt_eop ? VB_W'(BYTES) - VB_W'(nxt_last_empty) : VB_W'(BYTES);

        if (load_beat) begin
            beat_idx_d = nxt_idx;
            valid_d    = 1'b1;
            sop_d      = (nxt_idx == '0);
            eop_d      = nxt_eop;
            empty_d    = nxt_eop ? nxt_last_empty : '0;
        end else if (clear_beat) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
        end
    end

    avalon_st_beat_pattern #(
        .WIDTH(WIDTH),
        .BYTES(BYTES),
        .LEN_W(LEN_W),
        .VB_W (VB_W)
    ) u_beat_pattern (
        .pkt_idx_i    (nxt_pkt),
        .byte_off_i   (nxt_off),
        .mode_i       (nxt_mode),
        .seed_i       (nxt_seed),
        .valid_bytes_i(vbytes),
        .data_o       (pat_data)
    );

    always_comb begin
        data_d = data_q;
        if (load_beat) begin
            data_d = pat_data;
        end else if (clear_beat) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            nb_q         <= '0;
            last_empty_q <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            mode_q       <= PatIncr;
            seed_q       <= '0;
            gap_cnt_q    <= '0;
            beat_idx_q   <= '0;
            pkts_sent_q  <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nb_q         <= nb_d;
            last_empty_q <= last_empty_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            gap_cnt_q    <= gap_cnt_d;
            beat_idx_q   <= beat_idx_d;
            pkts_sent_q  <= pkts_sent_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign empty     = empty_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Randomized self-checking bench for avalon_st_pkt_gen (WIDTH = 64), with a
// packet-level reference model built from byte arithmetic.
`timescale 1ns/1ps
module tb_avalon_st_pkt_gen;

    localparam int B = 8;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  c;  // {sop, eop, empty}
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [7:0]  gap;
    logic        mode;
    logic [7:0]  seed;
    logic [63:0] data;
    logic        valid;
    logic        ready;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_eop_data;
    logic [2:0]  last_eop_empty;
    int          last_xfers;

    always #5 clk = ~clk;

    avalon_st_pkt_gen #(
        .WIDTH(64),
        .LEN_W(16),
        .GAP_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pkt_len  (pkt_len),
        .pkt_count(pkt_count),
        .gap      (gap),
        .mode     (mode),
        .seed     (seed),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .sop      (sop),
        .eop      (eop),
        .empty    (empty),
        .busy     (busy),
        .done     (done),
        .pkts_sent(pkts_sent)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int n, input int k, input bit md,
                                            input logic [7:0] sd);
        return md ? sd : 8'((int'(sd) + n + k) % 256);
    endfunction

    // Runs one packet run and checks every cycle until the done pulse.
    task automatic run_pkts(input int len, input int cnt, input int gp, input bit md,
                            input logic [7:0] sd, input int rdy_pct, input bit poke);
        beat_t q[$];
        beat_t b;
        beat_t held;
        int    l, nb, sent, gap_seen, xfers;
        bit    stalled, want_gap, final_seen, finished;

        l  = (len == 0) ? 1 : len;
        nb = (l + B - 1) / B;
        for (int n = 0; n < cnt; n++) begin
            for (int j = 0; j < nb; j++) begin
                b.d = '0;
                for (int i = 0; i < B; i++) begin
                    if (j * B + i < l) b.d[63-8*i -: 8] = ref_byte(n, j * B + i, md, sd);
                end
                b.c = {1'(j == 0), 1'(j == nb - 1), (j == nb - 1) ? 3'(nb * B - l) : 3'd0};
                q.push_back(b);
            end
        end

        @(negedge clk);
        pkt_len   = 16'(len);
        pkt_count = 16'(cnt);
        gap       = 8'(gp);
        mode      = md;
        seed      = sd;
        ready     = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        pkt_len   = 16'($urandom);
        pkt_count = 16'($urandom);
        gap       = 8'($urandom);
        mode      = 1'($urandom);
        seed      = 8'($urandom);
        check("first_beat", {62'd0, valid, sop}, 64'd3);

        sent = 0; gap_seen = 0; xfers = 0;
        stalled = 0; want_gap = 0; final_seen = 0; finished = 0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            ready = ($urandom_range(99) < rdy_pct);
            start = poke && busy && ($urandom_range(7) == 0);
            if (final_seen) begin
                check("done_after_last", {62'd0, busy, done}, 64'd3);
                check("pkts_sent_end", 64'(pkts_sent), 64'(cnt));
                check("valid_at_done", 64'(valid), 64'd0);
                finished = 1;
            end else begin
                check("busy_no_done", {62'd0, busy, done}, 64'd2);
                check("pkts_sent", 64'(pkts_sent), 64'(sent));
                if (valid) begin
                    if (stalled) begin
                        check("hold_data", data, held.d);
                        check("hold_ctl", 64'({sop, eop, empty}), 64'(held.c));
                    end
                    if (want_gap) begin
                        check("gap_len", 64'(gap_seen), 64'(gp));
                        want_gap = 0;
                    end
                    if (ready) begin
                        stalled = 0;
                        xfers++;
                        if (q.size() == 0) begin
                            check("extra_beat", 64'd1, 64'd0);
                        end else begin
                            b = q.pop_front();
                            check("data", data, b.d);
                            check("ctl", 64'({sop, eop, empty}), 64'(b.c));
                        end
                        if (eop) begin
                            sent++;
                            last_eop_data  = data;
                            last_eop_empty = empty;
                            if (q.size() == 0) final_seen = 1;
                            else begin
                                want_gap = 1;
                                gap_seen = 0;
                            end
                        end
                    end else begin
                        stalled = 1;
                        held.d  = data;
                        held.c  = {sop, eop, empty};
                    end
                end else begin
                    if (stalled) check("valid_dropped", 64'd0, 64'd1);
                    stalled = 0;
                    if (want_gap) gap_seen++;
                end
            end
        end
        start = 1'b0;
        if (!finished) check("run_timeout", 64'd0, 64'd1);
        last_xfers = xfers;
        @(negedge clk);
        check("done_pulse", {61'd0, busy, done, valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        pkt_len = '0; pkt_count = '0; gap = '0; mode = 1'b0; seed = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({valid, sop, eop, empty, busy, done}), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_pkts_sent", 64'(pkts_sent), 64'd0);
        rst = 1'b0;

        run_pkts(24, 1, 0, 1'b0, 8'h00, 100, 1'b0);
        check("len24_last", last_eop_data, 64'h10111213_14151617);
        check("len24_xfers", 64'(last_xfers), 64'd3);
        check("len24_sent_hold", 64'(pkts_sent), 64'd1);

        run_pkts(20, 1, 0, 1'b0, 8'h00, 100, 1'b0);
        check("len20_eop_data", last_eop_data, 64'h10111213_00000000);
        check("len20_empty", 64'(last_eop_empty), 64'd4);

        run_pkts(24, 1, 0, 1'b0, 8'h00, 40, 1'b1);
        check("stall_xfers", 64'(last_xfers), 64'd3);

        run_pkts(8, 3, 2, 1'b0, 8'h40, 100, 1'b0);
        check("gap2_last", last_eop_data, 64'h42434445_46474849);
        run_pkts(8, 3, 0, 1'b0, 8'h40, 100, 1'b0);
        run_pkts(0, 2, 1, 1'b1, 8'hA5, 70, 1'b0);
        check("len0_data", last_eop_data, 64'hA5000000_00000000);
        check("len0_empty", 64'(last_eop_empty), 64'd7);

        // Empty run: done straight away, no beats.
        @(negedge clk);
        pkt_len = 16'd24; pkt_count = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cnt0_done", {61'd0, busy, done, valid}, 64'd6);
        check("cnt0_sent", 64'(pkts_sent), 64'd0);
        @(negedge clk);
        check("cnt0_idle", {61'd0, busy, done, valid}, 64'd0);

        // Reset in the middle of a packet.
        pkt_len = 16'd24; pkt_count = 16'd1; gap = 8'd0; mode = 1'b0; seed = 8'd0;
        ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_beat1", {62'd0, valid, sop}, 64'd2);
        rst = 1'b1;
        #1;
        check("midrst_ctl", 64'({valid, sop, eop, empty, busy, done}), 64'd0);
        check("midrst_data", data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_pkts(24, 1, 0, 1'b0, 8'h00, 100, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_pkts($urandom_range(40), $urandom_range(4, 1), $urandom_range(3),
                     1'($urandom), 8'($urandom), $urandom_range(100, 40), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
